// File: rtl/branch_resolve.sv
// Branch resolution stage: evaluates a condition code against captured
// compare flags and produces the resolved next pc.
module branch_resolve (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmp_lt,
  input  logic        cmp_eq,
  input  logic        cmp_gt,
  input  logic        flag_we,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_cond,
  input  logic [19:0] br_pc,
  input  logic [19:0] br_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_taken,
  output logic [19:0] out_next_pc,
  output logic        flags_valid,
  output logic        flag_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FLAGS,
    HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  flags_q, flags_d;
  logic        fvalid_q, fvalid_d;
  logic        ferr_q, ferr_d;
  logic [2:0]  cond_q, cond_d;
  logic [19:0] pc_q, pc_d;
  logic [19:0] tgt_q, tgt_d;
  logic        oval_q, oval_d;
  logic        otaken_q, otaken_d;
  logic [19:0] onpc_q, onpc_d;

  logic [2:0]  cmp;
  logic        accept;
  logic        taken;
  logic        needs;

  // f is {lt, eq, gt}
  function automatic logic cond_true(input logic [2:0] c,
                                     input logic [2:0] f);
    case (c)
      3'b000:  return 1'b0;
      3'b001:  return f[2];
      3'b010:  return f[1];
      3'b011:  return f[2] | f[1];
      3'b100:  return f[0];
      3'b101:  return ~f[1];
      3'b110:  return f[0] | f[1];
      default: return 1'b1;
    endcase
  endfunction

  assign cmp      = {cmp_lt, cmp_eq, cmp_gt};
  assign br_ready = (state_q == IDLE) && !rst;
  assign accept   = br_valid && br_ready;
  assign needs    = (br_cond != 3'b000) && (br_cond != 3'b111);

  always_comb begin
    state_d  = state_q;
    flags_d  = flags_q;
    fvalid_d = fvalid_q;
    ferr_d   = ferr_q;
    cond_d   = cond_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    oval_d   = oval_q;
    otaken_d = otaken_q;
    onpc_d   = onpc_q;
    taken    = 1'b0;

    if (flag_we) begin
      flags_d  = cmp;
      fvalid_d = 1'b1;
      if (!$onehot(cmp)) ferr_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          cond_d = br_cond;
          pc_d   = br_pc;
          tgt_d  = br_target;
          if (!needs || fvalid_q || flag_we) begin
            // same-cycle flag write bypasses the stored flags
            taken    = cond_true(br_cond, flag_we ? cmp : flags_q);
            otaken_d = taken;
            onpc_d   = taken ? br_target : br_pc + 20'd1;
            oval_d   = 1'b1;
            state_d  = HOLD;
          end else begin
            state_d = WAIT_FLAGS;
          end
        end
      end
      WAIT_FLAGS: begin
        if (flag_we) begin
          taken    = cond_true(cond_q, cmp);
          otaken_d = taken;
          onpc_d   = taken ? tgt_q : pc_q + 20'd1;
          oval_d   = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          oval_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      flags_q  <= 3'b000;
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      cond_q   <= 3'b000;
      pc_q     <= 20'd0;
      tgt_q    <= 20'd0;
      oval_q   <= 1'b0;
      otaken_q <= 1'b0;
      onpc_q   <= 20'd0;
    end else begin
      state_q  <= state_d;
      flags_q  <= flags_d;
      fvalid_q <= fvalid_d;
      ferr_q   <= ferr_d;
      cond_q   <= cond_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      oval_q   <= oval_d;
      otaken_q <= otaken_d;
      onpc_q   <= onpc_d;
    end
  end

  assign out_valid   = oval_q;
  assign out_taken   = otaken_q;
  assign out_next_pc = onpc_q;
  assign flags_valid = fvalid_q;
  assign flag_err    = ferr_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed and random checks of branch_resolve against a queue-based
// reference model.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst, cmp_lt, cmp_eq, cmp_gt, flag_we, br_valid;
  logic        br_ready, out_valid, out_ready, out_taken;
  logic        flags_valid, flag_err;
  logic [2:0]  br_cond;
  logic [19:0] br_pc, br_target, out_next_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve dut (
    .clk(clk), .rst(rst),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .flag_we(flag_we), .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_pc(br_pc), .br_target(br_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_next_pc(out_next_pc),
    .flags_valid(flags_valid), .flag_err(flag_err)
  );

  typedef struct packed {
    logic [2:0]  cond;
    logic [19:0] pc;
    logic [19:0] tgt;
  } req_t;

  req_t        pend[$];
  int          res_n = 0;
  logic [2:0]  m_flags = 3'b000;
  logic        m_fv = 1'b0;
  logic        m_err = 1'b0;
  logic        m_taken = 1'b0;
  logic [19:0] m_npc = 20'd0;

  // f is {lt, eq, gt}
  function automatic logic ref_taken(input logic [2:0] c,
                                     input logic [2:0] f);
    logic any;
    any = (c[0] & f[2]) | (c[1] & f[1]) | (c[2] & f[0]);
    if (c == 3'd7) return 1'b1;
    if (c == 3'd5) return !f[1];
    return any;
  endfunction

  task automatic resolve(input req_t r, input logic [2:0] f);
    m_taken = ref_taken(r.cond, f);
    m_npc   = m_taken ? r.tgt : r.pc + 20'd1;
    res_n   = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [2:0] cmp,
                     input logic fwe, input logic bv,
                     input logic [2:0] cond, input logic [19:0] pc,
                     input logic [19:0] tgt, input logic ordy);
    logic idle, needs;
    req_t rq;
    @(negedge clk);
    rst = r;
    {cmp_lt, cmp_eq, cmp_gt} = cmp;
    flag_we = fwe; br_valid = bv; br_cond = cond;
    br_pc = pc; br_target = tgt; out_ready = ordy;
    #1;
    idle = (pend.size() == 0) && (res_n == 0);
    chk("br_ready", br_ready, !r && idle);
    if (r) begin
      pend.delete();
      res_n = 0; m_flags = 3'b000; m_fv = 0; m_err = 0;
      m_taken = 0; m_npc = 0;
    end else begin
      if (res_n != 0 && ordy) res_n = 0;
      if (pend.size() != 0 && fwe) resolve(pend.pop_front(), cmp);
      if (idle && bv) begin
        rq = '{cond, pc, tgt};
        needs = (cond != 3'd0) && (cond != 3'd7);
        if (needs && !m_fv && !fwe) pend.push_back(rq);
        else resolve(rq, fwe ? cmp : m_flags);
      end
      if (fwe) begin
        m_flags = cmp;
        m_fv = 1;
        if (!$onehot(cmp)) m_err = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, res_n != 0);
    chk("out_taken", out_taken, m_taken);
    chk("out_next_pc", out_next_pc, m_npc);
    chk("flags_valid", flags_valid, m_fv);
    chk("flag_err", flag_err, m_err);
  endtask

  task automatic nop(input logic ordy);
    cyc(0, 3'b000, 0, 0, 3'd0, 20'd0, 20'd0, ordy);
  endtask

  task automatic reset();
    cyc(1, 3'b000, 0, 0, 3'd0, 20'd0, 20'd0, 0);
  endtask

  initial begin
    logic [2:0]  rc, rcmp;
    logic [19:0] rpc;
    reset();
    reset();
    chk("rst_npc", out_next_pc, 20'd0);

    // eq flags then branch on eq
    cyc(0, 3'b010, 1, 0, 3'd0, 20'd0, 20'd0, 0);
    cyc(0, 3'b000, 0, 1, 3'd2, 20'h00100, 20'h00200, 0);
    chk("eq_taken", out_taken, 1);
    chk("eq_npc", out_next_pc, 20'h00200);
    nop(1);

    // no flags: wait, then resolve
    reset();
    cyc(0, 3'b000, 0, 1, 3'd1, 20'h00010, 20'h00055, 0);
    chk("wait_ov", out_valid, 0);
    nop(0);
    cyc(0, 3'b100, 1, 0, 3'd0, 20'd0, 20'd0, 0);
    chk("wait_npc", out_next_pc, 20'h00055);
    nop(1);
    reset();
    cyc(0, 3'b000, 0, 1, 3'd1, 20'h00010, 20'h00055, 0);
    nop(0);
    cyc(0, 3'b001, 1, 0, 3'd0, 20'd0, 20'd0, 0);
    chk("wait_nt_npc", out_next_pc, 20'h00011);
    nop(1);

    // bypass: stored gt, incoming lt
    cyc(0, 3'b001, 1, 0, 3'd0, 20'd0, 20'd0, 0);
    cyc(0, 3'b100, 1, 1, 3'd1, 20'h00300, 20'h00400, 0);
    chk("bypass_taken", out_taken, 1);
    nop(1);

    // always / never with wrap
    cyc(0, 3'b000, 0, 1, 3'd7, 20'hFFFFF, 20'h12345, 1);
    chk("always_npc", out_next_pc, 20'h12345);
    nop(1);
    cyc(0, 3'b000, 0, 1, 3'd0, 20'hFFFFF, 20'h12345, 0);
    chk("never_wrap", out_next_pc, 20'h00000);
    nop(1);

    // hold stable under backpressure and flag writes
    cyc(0, 3'b000, 0, 1, 3'd4, 20'h00020, 20'h00777, 0);
    nop(0);
    nop(0);
    cyc(0, 3'b010, 1, 0, 3'd0, 20'd0, 20'd0, 0);
    nop(0);
    nop(0);
    nop(1);
    nop(0);

    // non-one-hot flags, then reset in hold and in wait
    cyc(0, 3'b110, 1, 0, 3'd0, 20'd0, 20'd0, 0);
    nop(0);
    chk("err_sticky", flag_err, 1);
    cyc(0, 3'b000, 0, 1, 3'd7, 20'h00001, 20'h00002, 0);
    reset();
    chk("err_clr", flag_err, 0);
    cyc(0, 3'b000, 0, 1, 3'd3, 20'h00009, 20'h00099, 0);
    reset();
    nop(0);
    chk("abort_ov", out_valid, 0);

    for (int i = 0; i < 600; i++) begin
      rc   = 3'($urandom_range(0, 7));
      rcmp = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7))
           : 3'(1 << $urandom_range(0, 2));
      rpc  = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'($urandom);
      cyc($urandom_range(0, 49) == 0, rcmp, $urandom_range(0, 3) == 0,
          1'($urandom), rc, rpc, 20'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
